// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: default widths,
// timeout depth and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_REQ    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DRAIN  = 3'd5
  } fetch_state_t;

  // States in which a memory read is outstanding and an ack is expected.
  function automatic logic is_mem_phase(input fetch_state_t s);
    return (s == ST_REQ) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/instr_fetch_wdog.sv
// Memory-ack watchdog: cleared on entry to a memory phase, counts ack-less
// cycles and flags expiry on the TIMEOUT-th consecutive one.
module instr_fetch_wdog
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (tick && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Counter holds cycles already waited, so expiry fires in the TIMEOUT-th cycle.
  assign expire = tick && !clr && (count_reg == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer between the PC and decode: reads program memory over
// req/ack, hands words to decode over valid/ready and steers the PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_din,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              fetch_err
);

  fetch_state_t state_reg;
  logic         in_mem;
  logic         wdog_clr;
  logic         wdog_tick;
  logic         wdog_expire;

  assign in_mem    = is_mem_phase(state_reg);
  assign wdog_tick = in_mem && !mem_ack;
  // A redirect that turns REQ into DRAIN starts a fresh wait for the stale ack.
  assign wdog_clr  = !in_mem || ((state_reg == ST_REQ) && redirect && !mem_ack);

  instr_fetch_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wdog_clr),
    .tick  (wdog_tick),
    .expire(wdog_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_inc    <= 1'b0;
      pc_load   <= 1'b0;
      pc_din    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      pc_inc  <= 1'b0;
      pc_load <= 1'b0;

      if (redirect) begin
        pc_load  <= 1'b1;
        pc_din   <= redirect_addr;
        ir_valid <= 1'b0;
        mem_req  <= 1'b0;
        case (state_reg)
          ST_IDLE:  state_reg <= ST_IDLE;
          // An ack still owed by memory must be swallowed in DRAIN.
          ST_REQ:   state_reg <= mem_ack ? ST_SETTLE : ST_DRAIN;
          ST_DRAIN: state_reg <= mem_ack ? ST_SETTLE : ST_DRAIN;
          default:  state_reg <= ST_SETTLE;
        endcase
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (en && !fetch_err) begin
              state_reg <= ST_ADDR;
            end
          end
          ST_SETTLE: begin
            state_reg <= ST_ADDR;
          end
          ST_ADDR: begin
            mem_addr  <= pc_addr;
            ir_pc     <= pc_addr;
            mem_req   <= 1'b1;
            state_reg <= ST_REQ;
          end
          ST_REQ: begin
            if (mem_ack) begin
              ir        <= mem_rdata;
              ir_valid  <= 1'b1;
              pc_inc    <= 1'b1;
              mem_req   <= 1'b0;
              state_reg <= ST_HOLD;
            end else if (wdog_expire) begin
              fetch_err <= 1'b1;
              mem_req   <= 1'b0;
              ir_valid  <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (ir_ready) begin
              ir_valid  <= 1'b0;
              state_reg <= en ? ST_ADDR : ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (mem_ack) begin
              state_reg <= ST_ADDR;
            end else if (wdog_expire) begin
              fetch_err <= 1'b1;
              ir_valid  <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run scored against a PC/memory environment and a fetch-order model.
module tb_instr_fetch;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic [AW-1:0] pc_addr;
  logic          pc_inc;
  logic          pc_load;
  logic [AW-1:0] pc_din;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          fetch_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [AW-1:0] pc_model;
  logic [DW-1:0] mem [512];

  instr_fetch #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pc_addr      (pc_addr),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_din       (pc_din),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .fetch_err    (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle; the PC register model follows the strobes of the cycle just ended.
  task automatic tick();
    logic          inc_s;
    logic          load_s;
    logic [AW-1:0] din_s;
    inc_s  = pc_inc;
    load_s = pc_load;
    din_s  = pc_din;
    @(posedge clk);
    if (load_s) pc_model = din_s;
    else if (inc_s) pc_model = pc_model + 1'b1;
    @(negedge clk);
    pc_addr = pc_model;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (!mem_req && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    pc_model = '0; pc_addr = '0;
    do_reset();
    checks++; if ({pc_inc, pc_load, mem_req, ir_valid, fetch_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {pc_inc, pc_load, mem_req, ir_valid, fetch_err});
    end
    checks++; if ({pc_din, mem_addr, ir_pc} !== 27'd0) begin
      errors++; $display("FAIL reset_addrs: got pc_din=%h mem_addr=%h ir_pc=%h expected 0", pc_din, mem_addr, ir_pc);
    end
    checks++; if (ir !== 16'h0) begin
      errors++; $display("FAIL reset_ir: got %h expected 0000", ir);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got %b expected 0", mem_req);
    end
    $display("reset: outputs cleared, idle with en=0");
  endtask

  task automatic test_first_fetch();
    int n;
    pc_model = 9'h00B; pc_addr = pc_model; en = 1'b1;
    wait_req(20, n);
    checks++; if (n !== 2 || mem_req !== 1'b1) begin
      errors++; $display("FAIL first_req_latency: got %0d cycles req=%b expected 2 cycles req=1", n, mem_req);
    end
    checks++; if (mem_addr !== 9'h00B) begin
      errors++; $display("FAIL first_mem_addr: got %h expected 00b", mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (ir !== 16'h1234 || ir_pc !== 9'h00B || ir_valid !== 1'b1) begin
      errors++; $display("FAIL first_ir: got ir=%h ir_pc=%h valid=%b expected 1234 00b 1", ir, ir_pc, ir_valid);
    end
    checks++; if (pc_inc !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL first_inc: got pc_inc=%b mem_req=%b expected 1 0", pc_inc, mem_req);
    end
    $display("fetch: addr=%h ir=%h", ir_pc, ir);
  endtask

  task automatic test_hold_stall();
    int n;
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ir !== 16'h1234 || ir_pc !== 9'h00B || ir_valid !== 1'b1) begin
        errors++; $display("FAIL hold_stable[%0d]: got ir=%h ir_pc=%h valid=%b expected 1234 00b 1", i, ir, ir_pc, ir_valid);
      end
      checks++; if (mem_req !== 1'b0 || pc_inc !== 1'b0) begin
        errors++; $display("FAIL hold_quiet[%0d]: got mem_req=%b pc_inc=%b expected 0 0", i, mem_req, pc_inc);
      end
    end
    checks++; if (pc_model !== 9'h00C) begin
      errors++; $display("FAIL single_inc: got pc=%h expected 00c", pc_model);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got valid=%b expected 0", ir_valid);
    end
    wait_req(20, n);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 9'h00C) begin
      errors++; $display("FAIL next_fetch: got req=%b addr=%h expected 1 00c", mem_req, mem_addr);
    end
    $display("stall: held 5 cycles, next request at %h", mem_addr);
  endtask

  task automatic test_redirect_drain();
    int loads, incs;
    redirect = 1'b1; redirect_addr = 9'h040; mem_ack = 1'b0;
    tick();
    redirect = 1'b0;
    checks++; if (pc_load !== 1'b1 || pc_din !== 9'h040 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL redir_load: got load=%b din=%h req=%b valid=%b expected 1 040 0 0", pc_load, pc_din, mem_req, ir_valid);
    end
    loads = 0; incs = 0;
    for (int i = 0; i < 3; i++) begin
      loads += int'(pc_load); incs += int'(pc_inc);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    loads += int'(pc_load); incs += int'(pc_inc);
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL drain_discard: got valid=%b req=%b expected 0 0", ir_valid, mem_req);
    end
    tick();
    checks++; if (loads !== 1 || incs !== 0) begin
      errors++; $display("FAIL drain_strobes: got loads=%0d incs=%0d expected 1 0", loads, incs);
    end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 9'h040) begin
      errors++; $display("FAIL drain_refetch: got req=%b addr=%h expected 1 040", mem_req, mem_addr);
    end
    $display("redirect(drain): target=%h refetch=%h", pc_din, mem_addr);
  endtask

  task automatic test_redirect_with_ack();
    mem_ack = 1'b1; mem_rdata = 16'h5555; redirect = 1'b1; redirect_addr = 9'h100;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0;
    checks++; if (ir_valid !== 1'b0 || pc_inc !== 1'b0) begin
      errors++; $display("FAIL redir_ack_drop: got valid=%b inc=%b expected 0 0", ir_valid, pc_inc);
    end
    checks++; if (pc_load !== 1'b1 || pc_din !== 9'h100) begin
      errors++; $display("FAIL redir_ack_load: got load=%b din=%h expected 1 100", pc_load, pc_din);
    end
    tick();
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL settle_bubble: got req=%b expected 0", mem_req);
    end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 9'h100 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL settle_refetch: got req=%b addr=%h valid=%b expected 1 100 0", mem_req, mem_addr, ir_valid);
    end
    $display("redirect(ack): target=%h refetch=%h", pc_din, mem_addr);
  endtask

  task automatic test_timeout();
    int reqs;
    mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (fetch_err !== 1'b0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got err=%b req=%b expected 0 1", fetch_err, mem_req);
    end
    tick();
    checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: got err=%b req=%b valid=%b expected 1 0 0", fetch_err, mem_req, ir_valid);
    end
    en = 1'b1; reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      reqs += int'(mem_req);
    end
    checks++; if (reqs !== 0 || fetch_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got reqs=%0d err=%b expected 0 1", reqs, fetch_err);
    end
    do_reset();
    checks++; if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got err=%b expected 0", fetch_err);
    end
    $display("timeout: fetch_err raised after 15 cycles, cleared by rst");
  endtask

  task automatic test_wrap_and_reset();
    int n;
    pc_model = 9'h1FF; pc_addr = pc_model; en = 1'b1;
    wait_req(20, n);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 9'h1FF) begin
      errors++; $display("FAIL wrap_first: got req=%b addr=%h expected 1 1ff", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (ir !== 16'hA5A5 || ir_pc !== 9'h1FF || pc_inc !== 1'b1) begin
      errors++; $display("FAIL wrap_ir: got ir=%h ir_pc=%h inc=%b expected a5a5 1ff 1", ir, ir_pc, pc_inc);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    wait_req(20, n);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 9'h000) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1 000", mem_req, mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({pc_inc, pc_load, mem_req, ir_valid, fetch_err} !== 5'b0 || ir !== 16'h0) begin
      errors++; $display("FAIL midreq_reset: got flags=%b ir=%h expected 00000 0000", {pc_inc, pc_load, mem_req, ir_valid, fetch_err}, ir);
    end
    checks++; if ({pc_din, mem_addr, ir_pc} !== 27'd0) begin
      errors++; $display("FAIL midreq_reset_addrs: got din=%h addr=%h ir_pc=%h expected 0", pc_din, mem_addr, ir_pc);
    end
    $display("wrap: 1ff -> 000, reset mid-request cleared outputs");
  endtask

  task automatic test_back_to_back();
    int last, count;
    logic [AW-1:0] exp_addr;
    do_reset();
    pc_model = 9'h020; pc_addr = pc_model; exp_addr = 9'h020;
    en = 1'b1; ir_ready = 1'b1; last = -1; count = 0;
    for (int c = 0; c < 40; c++) begin
      mem_ack = mem_req;
      mem_rdata = mem_req ? mem[mem_addr] : 16'h0;
      if (ir_valid && ir_ready) begin
        checks++; if (ir_pc !== exp_addr || ir !== mem[exp_addr]) begin
          errors++; $display("FAIL b2b_data: got %h@%h expected %h@%h", ir, ir_pc, mem[exp_addr], exp_addr);
        end
        if (last >= 0) begin
          checks++; if (cyc - last !== 3) begin
            errors++; $display("FAIL b2b_rate: got %0d cycles expected 3", cyc - last);
          end
        end
        $display("b2b deliver: addr=%h ir=%h", ir_pc, ir);
        last = cyc; count++; exp_addr = exp_addr + 1'b1;
      end
      tick();
    end
    mem_ack = 1'b0; ir_ready = 1'b0;
    checks++; if (count < 12) begin
      errors++; $display("FAIL b2b_count: got %0d expected >=12", count);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_addr, req_addr, prev_addr;
    logic          outstanding, prev_req;
    int            delay, delivered;
    do_reset();
    pc_model = 9'($urandom); pc_addr = pc_model; exp_addr = pc_model;
    outstanding = 1'b0; prev_req = 1'b0; prev_addr = '0; delay = 0; delivered = 0; req_addr = '0;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      redirect = ($urandom_range(0, 24) == 0);
      if (redirect) begin
        redirect_addr = 9'($urandom);
        ir_ready = 1'b0;
      end else begin
        ir_ready = ($urandom_range(0, 2) != 0);
      end
      if (prev_req && mem_req) begin
        checks++; if (mem_addr !== prev_addr) begin
          errors++; $display("FAIL rnd_addr_stable: got %h expected %h", mem_addr, prev_addr);
        end
      end
      if (!outstanding && mem_req) begin
        outstanding = 1'b1; req_addr = mem_addr; delay = int'($urandom_range(0, 3));
      end
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      if (outstanding) begin
        if (delay == 0) begin
          mem_ack = 1'b1; mem_rdata = mem[req_addr]; outstanding = 1'b0;
        end else begin
          delay--;
        end
      end
      if (ir_valid && ir_ready) begin
        checks++; if (ir_pc !== exp_addr || ir !== mem[exp_addr]) begin
          errors++; $display("FAIL rnd_deliver: got %h@%h expected %h@%h", ir, ir_pc, mem[exp_addr], exp_addr);
        end
        $display("rnd deliver: addr=%h ir=%h", ir_pc, ir);
        exp_addr = exp_addr + 1'b1; delivered++;
      end
      if (redirect) exp_addr = redirect_addr;
      checks++; if ((pc_inc && pc_load) || fetch_err !== 1'b0) begin
        errors++; $display("FAIL rnd_strobes: got inc=%b load=%b err=%b expected no overlap, err=0", pc_inc, pc_load, fetch_err);
      end
      prev_req = mem_req; prev_addr = mem_addr;
      tick();
    end
    redirect = 1'b0; ir_ready = 1'b0; mem_ack = 1'b0;
    checks++; if (delivered < 100) begin
      errors++; $display("FAIL rnd_progress: got %0d deliveries expected >=100", delivered);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; redirect = 1'b0; redirect_addr = '0; pc_model = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_drain();
    test_redirect_with_ack();
    test_timeout();
    test_wrap_and_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
